card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 194 +++++++++++++++++++
 tb/tb_card_dealer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deck init, LFSR Fisher-Yates shuffle and hole/board dealing for one poker table
package poker_types;
    typedef enum logic [1:0] {
        SUIT_SPADES, SUIT_HEARTS, SUIT_DIAMONDS, SUIT_CLUBS
    } suit_t;

    typedef enum logic [3:0] {
        RANK_ACE, RANK_TWO, RANK_THREE, RANK_FOUR, RANK_FIVE, RANK_SIX, RANK_SEVEN,
        RANK_EIGHT, RANK_NINE, RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING
    } rank_t;

    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;
endpackage

module card_dealer
    import poker_types::*;
#(
    parameter int          NUM_PLAYERS = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   dealer_reset,
    input  logic                   start_hand,
    input  logic                   deal_hole,
    input  logic [2:0]             player_idx,
    input  logic                   deal_board,
    input  logic [1:0]             board_n,
    output logic                   ready,
    output card_t [1:0]            dealt_cards,
    output logic [NUM_PLAYERS-1:0] set_cards,
    output card_t [4:0]            board,
    output logic [2:0]             board_count,
    output logic [5:0]             deck_remaining,
    output logic                   deal_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SHUFFLE, ST_READY} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [15:0]            r_lfsr;
    logic [5:0]             r_deck [0:51];
    logic [5:0]             r_top;
    logic [5:0]             r_i;
    logic [2:0]             r_board_count;
    card_t [1:0]            r_dealt;
    card_t [4:0]            r_board;
    logic [NUM_PLAYERS-1:0] r_set_cards;
    logic                   r_deal_err;

    logic [5:0]             w_remaining;
    logic [5:0]             w_mask;
    logic [5:0]             w_cand;
    logic                   w_swap;
    logic                   w_seat_bad;
    logic                   w_board_bad;
    logic [3:0]             w_board_sum;
    logic                   w_hole_ok;
    logic                   w_hole_err;
    logic                   w_board_ok;
    logic                   w_board_err;

    function automatic card_t to_card(input logic [5:0] k);
        card_t      c;
        logic [5:0] r;
        if (k < 6'd13) begin
            c.suit = SUIT_SPADES;
            r      = k;
        end else if (k < 6'd26) begin
            c.suit = SUIT_HEARTS;
            r      = k - 6'd13;
        end else if (k < 6'd39) begin
            c.suit = SUIT_DIAMONDS;
            r      = k - 6'd26;
        end else begin
            c.suit = SUIT_CLUBS;
            r      = k - 6'd39;
        end
        c.rank = rank_t'(r[3:0]);
        return c;
    endfunction

    assign w_remaining = 6'd52 - r_top;

    // Candidate swap partner is drawn from the smallest all-ones window covering i, then rejected if > i.
    always_comb begin
        if (r_i > 6'd31)      w_mask = 6'd63;
        else if (r_i > 6'd15) w_mask = 6'd31;
        else if (r_i > 6'd7)  w_mask = 6'd15;
        else if (r_i > 6'd3)  w_mask = 6'd7;
        else if (r_i > 6'd1)  w_mask = 6'd3;
        else                  w_mask = 6'd1;
    end

    assign w_cand      = r_lfsr[5:0] & w_mask;
    assign w_swap      = (r_state == ST_SHUFFLE) && (w_cand <= r_i);
    assign w_seat_bad  = (32'(player_idx) >= NUM_PLAYERS);
    assign w_board_sum = {1'b0, r_board_count} + {2'b0, board_n};
    assign w_board_bad = !(board_n == 2'd1 || board_n == 2'd3) ||
                         (w_board_sum > 4'd5) ||
                         (w_remaining < ({4'b0, board_n} + 6'd1));

    always_ff @(posedge clk) begin
        if (dealer_reset) r_state <= ST_IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_hole_ok   = 1'b0;
        w_hole_err  = 1'b0;
        w_board_ok  = 1'b0;
        w_board_err = 1'b0;
        case (r_state)
            ST_IDLE:    if (start_hand) w_next = ST_INIT;
            ST_INIT:    w_next = ST_SHUFFLE;
            ST_SHUFFLE: if (w_swap && r_i == 6'd1) w_next = ST_READY;
            ST_READY: begin
                if (start_hand) begin
                    w_next = ST_INIT;
                end else if (deal_hole) begin
                    if (w_seat_bad || w_remaining < 6'd2) w_hole_err = 1'b1;
                    else                                  w_hole_ok  = 1'b1;
                end else if (deal_board) begin
                    if (w_board_bad) w_board_err = 1'b1;
                    else             w_board_ok  = 1'b1;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (dealer_reset) begin
            r_lfsr        <= LFSR_SEED;
            r_top         <= 6'd0;
            r_i           <= 6'd0;
            r_board_count <= 3'd0;
            r_set_cards   <= '0;
            r_deal_err    <= 1'b0;
            r_dealt       <= {2{to_card(6'd0)}};
            r_board       <= {5{to_card(6'd0)}};
            for (int k = 0; k < 52; k++) r_deck[k] <= 6'(k);
        end else begin
            r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_set_cards <= '0;
            r_deal_err  <= w_hole_err | w_board_err;

            if (r_state == ST_INIT) begin
                for (int k = 0; k < 52; k++) r_deck[k] <= 6'(k);
                r_top         <= 6'd0;
                r_board_count <= 3'd0;
                r_i           <= 6'd51;
            end

            if (w_swap) begin
                r_deck[r_i]    <= r_deck[w_cand];
                r_deck[w_cand] <= r_deck[r_i];
                r_i            <= r_i - 6'd1;
            end

            if (w_hole_ok) begin
                r_dealt[0]  <= to_card(r_deck[r_top]);
                r_dealt[1]  <= to_card(r_deck[r_top + 6'd1]);
                r_set_cards <= NUM_PLAYERS'(1) << player_idx;
                r_top       <= r_top + 6'd2;
            end

            // The card at top is burned; board cards start one past it.
            if (w_board_ok) begin
                for (int e = 0; e < 5; e++) begin
                    for (int j = 0; j < 3; j++) begin
                        if (j < int'(board_n) && e == int'(r_board_count) + j)
                            r_board[e] <= to_card(r_deck[r_top + 6'(j + 1)]);
                    end
                end
                r_top         <= r_top + 6'd1 + {4'b0, board_n};
                r_board_count <= r_board_count + {1'b0, board_n};
            end
        end
    end

    assign ready          = (r_state == ST_READY);
    assign dealt_cards    = r_dealt;
    assign set_cards      = r_set_cards;
    assign board          = r_board;
    assign board_count    = r_board_count;
    assign deck_remaining = w_remaining;
    assign deal_err       = r_deal_err;

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed checks of card_dealer against a shuffle model
module tb_card_dealer;
    localparam int          NP   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          dealer_reset = 1'b0;
    logic          start_hand = 1'b0;
    logic          deal_hole = 1'b0;
    logic [2:0]    player_idx = 3'd0;
    logic          deal_board = 1'b0;
    logic [1:0]    board_n = 2'd0;
    logic          ready;
    logic [11:0]   dealt_cards;
    logic [NP-1:0] set_cards;
    logic [29:0]   board;
    logic [2:0]    board_count;
    logic [5:0]    deck_remaining;
    logic          deal_err;

    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    int          m_deck [52];
    int          order [52];
    int          run_a [52];
    int          run_b [52];
    int          diffs;
    logic [15:0] l0;

    card_dealer #(.NUM_PLAYERS(NP), .LFSR_SEED(SEED)) dut (
        .clk(clk), .dealer_reset(dealer_reset), .start_hand(start_hand),
        .deal_hole(deal_hole), .player_idx(player_idx), .deal_board(deal_board),
        .board_n(board_n), .ready(ready), .dealt_cards(dealt_cards),
        .set_cards(set_cards), .board(board), .board_count(board_count),
        .deck_remaining(deck_remaining), .deal_err(deal_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk) m_lfsr <= dealer_reset ? SEED : step(m_lfsr);

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int card_of(input int k);
        return (k / 13) * 16 + (k % 13);
    endfunction

    function automatic int mask_of(input int i);
        int m = 1;
        while (m < i) m = m * 2 + 1;
        return m;
    endfunction

    task automatic build_model(input logic [15:0] start);
        logic [15:0] l = step(step(start));
        int i = 51;
        int c, t;
        int guard = 0;
        for (int k = 0; k < 52; k++) m_deck[k] = k;
        while (i > 0 && guard < 100000) begin
            c = int'(l[5:0]) & mask_of(i);
            if (c <= i) begin
                t = m_deck[i]; m_deck[i] = m_deck[c]; m_deck[c] = t;
                i--;
            end
            l = step(l);
            guard++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        dealer_reset = 1'b1;
        tick; tick;
        dealer_reset = 1'b0;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!ready && n < 5000) begin tick; n++; end
        chk("ready_wait", int'(ready), 1);
    endtask

    task automatic start_and_wait;
        l0 = m_lfsr;
        start_hand = 1'b1;
        tick;
        start_hand = 1'b0;
        build_model(l0);
        wait_ready;
    endtask

    task automatic hole(input int seat);
        player_idx = 3'(seat);
        deal_hole = 1'b1;
        tick;
        deal_hole = 1'b0;
    endtask

    task automatic brd(input int n);
        board_n = 2'(n);
        deal_board = 1'b1;
        tick;
        deal_board = 1'b0;
    endtask

    task automatic deal_all;
        logic [51:0] seen = '0;
        int ndist = 0;
        int c, idx;
        for (int d = 0; d < 26; d++) begin
            hole(d % 4);
            chk("hole_strobe", int'(set_cards), 1 << (d % 4));
            chk("hole_card0", int'(dealt_cards[5:0]), card_of(m_deck[2*d]));
            chk("hole_card1", int'(dealt_cards[11:6]), card_of(m_deck[2*d+1]));
            chk("hole_remaining", int'(deck_remaining), 50 - 2*d);
            for (int h = 0; h < 2; h++) begin
                c = (h == 0) ? int'(dealt_cards[5:0]) : int'(dealt_cards[11:6]);
                order[2*d+h] = c;
                idx = (c >> 4) * 13 + (c & 15);
                if ((c & 15) < 13 && !seen[idx]) begin seen[idx] = 1'b1; ndist++; end
            end
        end
        chk("distinct_cards", ndist, 52);
        chk("empty_remaining", int'(deck_remaining), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset;
        chk("rst_ready", int'(ready), 0);
        chk("rst_set_cards", int'(set_cards), 0);
        chk("rst_deal_err", int'(deal_err), 0);
        chk("rst_board_count", int'(board_count), 0);
        chk("rst_remaining", int'(deck_remaining), 52);
        chk("rst_dealt", int'(dealt_cards), 0);
        chk("rst_board", int'(board), 0);
        repeat (10) tick;
        chk("idle_ready", int'(ready), 0);
        chk("idle_remaining", int'(deck_remaining), 52);
        hole(0);
        chk("idle_hole_err", int'(deal_err), 0);
        chk("idle_hole_strobe", int'(set_cards), 0);

        do_reset; repeat (5) tick;
        start_and_wait;
        deal_all;
        run_a = order;
        hole(0);
        chk("27th_err", int'(deal_err), 1);
        chk("27th_strobe", int'(set_cards), 0);
        chk("27th_remaining", int'(deck_remaining), 0);
        chk("dealt_hold0", int'(dealt_cards[5:0]), run_a[50]);
        chk("dealt_hold1", int'(dealt_cards[11:6]), run_a[51]);
        tick;
        chk("err_pulse", int'(deal_err), 0);

        do_reset; repeat (5) tick;
        start_and_wait;
        deal_all;
        run_b = order;
        diffs = 0;
        for (int k = 0; k < 52; k++) if (run_a[k] != run_b[k]) diffs++;
        chk("same_seed_order", diffs, 0);

        do_reset; repeat (6) tick;
        start_and_wait;
        deal_all;
        diffs = 0;
        for (int k = 0; k < 52; k++) if (run_a[k] != order[k]) diffs++;
        chk("later_start_differs", int'(diffs > 0), 1);

        do_reset;
        start_and_wait;
        for (int s = 0; s < 4; s++) hole(s);
        chk("pre_board_remaining", int'(deck_remaining), 44);
        brd(2);
        chk("n2_err", int'(deal_err), 1);
        chk("n2_count", int'(board_count), 0);
        chk("n2_remaining", int'(deck_remaining), 44);
        brd(3);
        chk("flop_err", int'(deal_err), 0);
        chk("flop_count", int'(board_count), 3);
        chk("flop_remaining", int'(deck_remaining), 40);
        for (int e = 0; e < 3; e++) chk("flop_card", int'(board[e*6 +: 6]), card_of(m_deck[9+e]));
        brd(1);
        chk("turn_count", int'(board_count), 4);
        chk("turn_remaining", int'(deck_remaining), 38);
        chk("turn_card", int'(board[18 +: 6]), card_of(m_deck[13]));
        brd(1);
        chk("river_count", int'(board_count), 5);
        chk("river_remaining", int'(deck_remaining), 36);
        chk("river_card", int'(board[24 +: 6]), card_of(m_deck[15]));
        brd(1);
        chk("sixth_err", int'(deal_err), 1);
        chk("sixth_count", int'(board_count), 5);
        chk("sixth_remaining", int'(deck_remaining), 36);
        brd(3);
        chk("full_flop_err", int'(deal_err), 1);

        do_reset;
        start_and_wait;
        player_idx = 3'd1; board_n = 2'd3;
        deal_hole = 1'b1; deal_board = 1'b1;
        tick;
        deal_hole = 1'b0; deal_board = 1'b0;
        chk("both_strobe", int'(set_cards), 2);
        chk("both_count", int'(board_count), 0);
        chk("both_remaining", int'(deck_remaining), 50);
        chk("both_err", int'(deal_err), 0);
        hole(4);
        chk("bad_seat_err", int'(deal_err), 1);
        chk("bad_seat_strobe", int'(set_cards), 0);
        chk("bad_seat_remaining", int'(deck_remaining), 50);
        l0 = m_lfsr;
        player_idx = 3'd0; start_hand = 1'b1; deal_hole = 1'b1;
        tick;
        start_hand = 1'b0; deal_hole = 1'b0;
        chk("restart_strobe", int'(set_cards), 0);
        chk("restart_ready", int'(ready), 0);
        chk("restart_err", int'(deal_err), 0);
        tick;
        chk("restart_remaining", int'(deck_remaining), 52);
        chk("restart_count", int'(board_count), 0);
        build_model(l0);
        wait_ready;
        hole(2);
        chk("restart_card0", int'(dealt_cards[5:0]), card_of(m_deck[0]));
        chk("restart_card1", int'(dealt_cards[11:6]), card_of(m_deck[1]));

        l0 = m_lfsr;
        start_hand = 1'b1;
        tick;
        start_hand = 1'b0;
        repeat (4) tick;
        hole(0);
        chk("shuffle_hole_err", int'(deal_err), 0);
        chk("shuffle_hole_strobe", int'(set_cards), 0);
        chk("shuffle_ready", int'(ready), 0);
        dealer_reset = 1'b1;
        tick;
        dealer_reset = 1'b0;
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_remaining", int'(deck_remaining), 52);
        chk("midrst_strobe", int'(set_cards), 0);
        chk("midrst_err", int'(deal_err), 0);
        chk("midrst_count", int'(board_count), 0);
        start_and_wait;
        hole(3);
        chk("midrst_strobe_after", int'(set_cards), 8);
        chk("midrst_card0", int'(dealt_cards[5:0]), card_of(m_deck[0]));
        chk("midrst_card1", int'(dealt_cards[11:6]), card_of(m_deck[1]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
